// File: rtl/ad9364_stream_ctrl.sv
// AD9364 datapath stream sequencer (l_clk domain).
// Brings the transceiver interface up through a settle/prime phase, then gates
// RX writes and TX reads against FIFO watermarks. On stop it drains back to idle.
// Also keeps saturating RX-overflow and TX-underflow event counters for the host.
module ad9364_stream_ctrl #(
    parameter int FIFO_AW        = 12,
    parameter int SETTLE_CYCLES  = 64,
    parameter int TX_PRIME_LEVEL = 512,
    parameter int RX_HI_WATER    = 3584,
    parameter int RX_LO_WATER    = 2048,
    parameter int CNT_W          = 16
) (
    input  logic               l_clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               rx_en_req,
    input  logic               tx_en_req,
    input  logic [FIFO_AW:0]   rx_fifo_level,
    input  logic [FIFO_AW:0]   tx_fifo_level,
    input  logic               ctr_clear,
    output logic               enable,
    output logic               rx_write_allowed,
    output logic               tx_read_allowed,
    output logic               busy,
    output logic [1:0]         state,
    output logic [CNT_W-1:0]   rx_overflow_cnt,
    output logic [CNT_W-1:0]   tx_underflow_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0]    SETTLE_MAX = SW'(SETTLE_CYCLES - 1);
    localparam logic [FIFO_AW:0] PRIME_LVL  = (FIFO_AW+1)'(TX_PRIME_LEVEL);
    localparam logic [FIFO_AW:0] HI_LVL     = (FIFO_AW+1)'(RX_HI_WATER);
    localparam logic [FIFO_AW:0] LO_LVL     = (FIFO_AW+1)'(RX_LO_WATER);
    // TX must hold at least two words: the read strobe lands one cycle after
    // the level is sampled, so one word of margin covers that latency.
    localparam logic [FIFO_AW:0] TX_MIN_LVL = (FIFO_AW+1)'(2);
    localparam logic [FIFO_AW:0] EMPTY_LVL  = '0;

    state_t        cur;
    state_t        nxt;
    logic [SW-1:0] settle_cnt;
    logic          settle_done;
    logic          rx_mode;
    logic          tx_mode;
    logic          rx_throttle;
    logic          throttle_nxt;
    logic          tx_primed;
    logic          start_ok;
    logic          in_run;

    assign settle_done = (settle_cnt == SETTLE_MAX);
    assign tx_primed   = (tx_fifo_level >= PRIME_LVL);
    assign start_ok    = start && !stop && (rx_en_req || tx_en_req);
    assign in_run      = (cur == RUN);
    assign state       = cur;

    // Next-state logic; stop takes priority over start everywhere.
    always_comb begin
        nxt = cur;
        case (cur)
            IDLE: begin
                if (start_ok)
                    nxt = ARM;
            end
            ARM: begin
                if (stop)
                    nxt = IDLE;
                else if (settle_done && (!tx_mode || tx_primed))
                    nxt = RUN;
            end
            RUN: begin
                if (stop)
                    nxt = DRAIN;
            end
            DRAIN: begin
                if (settle_done)
                    nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // RX throttle hysteresis; only live while staying in RUN, zero otherwise so
    // every RUN entry starts unthrottled.
    always_comb begin
        throttle_nxt = 1'b0;
        if (in_run && (nxt == RUN)) begin
            if (rx_fifo_level >= HI_LVL)
                throttle_nxt = 1'b1;
            else if (rx_fifo_level <= LO_LVL)
                throttle_nxt = 1'b0;
            else
                throttle_nxt = rx_throttle;
        end
    end

    // State register.
    always_ff @(posedge l_clk or posedge rst) begin
        if (rst)
            cur <= IDLE;
        else
            cur <= nxt;
    end

    // Settle counter: restarts on every state change, saturates at its max.
    always_ff @(posedge l_clk or posedge rst) begin
        if (rst)
            settle_cnt <= '0;
        else if (nxt != cur)
            settle_cnt <= '0;
        else if (((cur == ARM) || (cur == DRAIN)) && !settle_done)
            settle_cnt <= settle_cnt + SW'(1);
    end

    // Stream modes are captured only when a start is accepted.
    always_ff @(posedge l_clk or posedge rst) begin
        if (rst) begin
            rx_mode <= 1'b0;
            tx_mode <= 1'b0;
        end else if ((cur == IDLE) && (nxt == ARM)) begin
            rx_mode <= rx_en_req;
            tx_mode <= tx_en_req;
        end
    end

    // Registered interface controls, computed from the upcoming state.
    always_ff @(posedge l_clk or posedge rst) begin
        if (rst) begin
            enable           <= 1'b0;
            busy             <= 1'b0;
            rx_throttle      <= 1'b0;
            rx_write_allowed <= 1'b0;
            tx_read_allowed  <= 1'b0;
        end else begin
            enable           <= (nxt != IDLE);
            busy             <= (nxt != IDLE);
            rx_throttle      <= throttle_nxt;
            rx_write_allowed <= (nxt == RUN) && rx_mode && !throttle_nxt;
            tx_read_allowed  <= in_run && (nxt == RUN) && tx_mode &&
                                (tx_fifo_level >= TX_MIN_LVL);
        end
    end

    // RX overflow counter: counts RUN cycles spent throttled.
    always_ff @(posedge l_clk or posedge rst) begin
        if (rst)
            rx_overflow_cnt <= '0;
        else if (ctr_clear)
            rx_overflow_cnt <= '0;
        else if (in_run && rx_mode && rx_throttle && !(&rx_overflow_cnt))
            rx_overflow_cnt <= rx_overflow_cnt + CNT_W'(1);
    end

    // TX underflow counter: counts RUN cycles with an empty TX FIFO.
    always_ff @(posedge l_clk or posedge rst) begin
        if (rst)
            tx_underflow_cnt <= '0;
        else if (ctr_clear)
            tx_underflow_cnt <= '0;
        else if (in_run && tx_mode && (tx_fifo_level == EMPTY_LVL) &&
                 !(&tx_underflow_cnt))
            tx_underflow_cnt <= tx_underflow_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_ad9364_stream_ctrl.sv
// Directed bench for ad9364_stream_ctrl (CNT_W=4 so saturation is reachable).
module tb_ad9364_stream_ctrl;
    localparam int AW = 12;
    localparam int CW = 4;

    logic          l_clk = 1'b0;
    logic          rst;
    logic          start, stop, rx_en_req, tx_en_req, ctr_clear;
    logic [AW:0]   rx_fifo_level, tx_fifo_level;
    logic          enable, rx_write_allowed, tx_read_allowed, busy;
    logic [1:0]    state;
    logic [CW-1:0] rx_overflow_cnt, tx_underflow_cnt;

    int vectors = 0;
    int errors  = 0;

    ad9364_stream_ctrl #(
        .FIFO_AW(AW), .SETTLE_CYCLES(64), .TX_PRIME_LEVEL(512),
        .RX_HI_WATER(3584), .RX_LO_WATER(2048), .CNT_W(CW)
    ) dut (
        .l_clk(l_clk), .rst(rst), .start(start), .stop(stop),
        .rx_en_req(rx_en_req), .tx_en_req(tx_en_req),
        .rx_fifo_level(rx_fifo_level), .tx_fifo_level(tx_fifo_level),
        .ctr_clear(ctr_clear), .enable(enable),
        .rx_write_allowed(rx_write_allowed), .tx_read_allowed(tx_read_allowed),
        .busy(busy), .state(state),
        .rx_overflow_cnt(rx_overflow_cnt), .tx_underflow_cnt(tx_underflow_cnt)
    );

    always #5 l_clk = ~l_clk;

    task automatic tick;
        @(posedge l_clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 0; stop = 0; rx_en_req = 0; tx_en_req = 0;
        ctr_clear = 0; rx_fifo_level = '0; tx_fifo_level = '0;
        #1;
        vectors++;
        if ({state, enable, busy, rx_write_allowed, tx_read_allowed, rx_overflow_cnt, tx_underflow_cnt} !== '0) begin
            errors++;
            $display("FAIL reset: st=%0d en=%0b busy=%0b rxa=%0b txa=%0b ovf=%0d ufl=%0d want all 0",
                     state, enable, busy, rx_write_allowed, tx_read_allowed, rx_overflow_cnt, tx_underflow_cnt);
        end
        tick; tick;
        rst = 1'b0;
        tick;
        vectors++;
        if (state !== 2'd0 || enable !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: st=%0d en=%0b want 0 0", state, enable);
        end
    endtask

    task automatic test_rx_start;
        rx_en_req = 1; tx_en_req = 0; start = 1;
        tick;
        start = 0; rx_en_req = 0;
        vectors++;
        if (state !== 2'd1 || enable !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL arm_entry: st=%0d en=%0b busy=%0b want 1 1 1", state, enable, busy);
        end
        repeat (63) tick;
        vectors++;
        if (state !== 2'd1 || rx_write_allowed !== 1'b0) begin
            errors++;
            $display("FAIL arm_last: st=%0d rxa=%0b want 1 0", state, rx_write_allowed);
        end
        tick;
        vectors++;
        if (state !== 2'd2 || rx_write_allowed !== 1'b1 || tx_read_allowed !== 1'b0 || enable !== 1'b1) begin
            errors++;
            $display("FAIL run_entry_rx: st=%0d rxa=%0b txa=%0b en=%0b want 2 1 0 1",
                     state, rx_write_allowed, tx_read_allowed, enable);
        end
    endtask

    task automatic test_rx_throttle;
        rx_fifo_level = 13'd3584;
        tick;
        vectors++;
        if (rx_write_allowed !== 1'b0 || rx_overflow_cnt !== 4'd0) begin
            errors++;
            $display("FAIL throttle_set: rxa=%0b ovf=%0d want 0 0", rx_write_allowed, rx_overflow_cnt);
        end
        tick; tick;
        vectors++;
        if (rx_overflow_cnt !== 4'd2) begin
            errors++;
            $display("FAIL ovf_count: got %0d want 2", rx_overflow_cnt);
        end
        rx_fifo_level = 13'd3000;
        tick;
        vectors++;
        if (rx_write_allowed !== 1'b0 || rx_overflow_cnt !== 4'd3) begin
            errors++;
            $display("FAIL throttle_hold: rxa=%0b ovf=%0d want 0 3", rx_write_allowed, rx_overflow_cnt);
        end
        rx_fifo_level = 13'd2048;
        tick;
        vectors++;
        if (rx_write_allowed !== 1'b1 || rx_overflow_cnt !== 4'd4) begin
            errors++;
            $display("FAIL throttle_release: rxa=%0b ovf=%0d want 1 4", rx_write_allowed, rx_overflow_cnt);
        end
        tick;
        vectors++;
        if (rx_overflow_cnt !== 4'd4) begin
            errors++;
            $display("FAIL ovf_stop: got %0d want 4", rx_overflow_cnt);
        end
    endtask

    task automatic test_drain;
        stop = 1;
        tick;
        stop = 0;
        vectors++;
        if (state !== 2'd3 || rx_write_allowed !== 1'b0 || tx_read_allowed !== 1'b0 || enable !== 1'b1) begin
            errors++;
            $display("FAIL drain_entry: st=%0d rxa=%0b txa=%0b en=%0b want 3 0 0 1",
                     state, rx_write_allowed, tx_read_allowed, enable);
        end
        rx_en_req = 1; start = 1;
        tick;
        start = 0; rx_en_req = 0;
        repeat (62) tick;
        vectors++;
        if (state !== 2'd3 || enable !== 1'b1) begin
            errors++;
            $display("FAIL drain_last: st=%0d en=%0b want 3 1", state, enable);
        end
        tick;
        vectors++;
        if (state !== 2'd0 || enable !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_exit: st=%0d en=%0b busy=%0b want 0 0 0", state, enable, busy);
        end
    endtask

    task automatic test_tx_prime;
        tx_en_req = 1; tx_fifo_level = 13'd100; start = 1;
        tick;
        start = 0; tx_en_req = 0;
        repeat (73) tick;
        vectors++;
        if (state !== 2'd1 || enable !== 1'b1) begin
            errors++;
            $display("FAIL prime_hold: st=%0d en=%0b want 1 1", state, enable);
        end
        tx_fifo_level = 13'd512;
        tick;
        vectors++;
        if (state !== 2'd2 || tx_read_allowed !== 1'b0 || rx_write_allowed !== 1'b0) begin
            errors++;
            $display("FAIL prime_run: st=%0d txa=%0b rxa=%0b want 2 0 0", state, tx_read_allowed, rx_write_allowed);
        end
        tick;
        vectors++;
        if (tx_read_allowed !== 1'b1) begin
            errors++;
            $display("FAIL tx_allowed: got %0b want 1", tx_read_allowed);
        end
    endtask

    task automatic test_underflow;
        ctr_clear = 1;
        tick;
        ctr_clear = 0;
        vectors++;
        if (rx_overflow_cnt !== 4'd0 || tx_underflow_cnt !== 4'd0) begin
            errors++;
            $display("FAIL ctr_clear: ovf=%0d ufl=%0d want 0 0", rx_overflow_cnt, tx_underflow_cnt);
        end
        tx_fifo_level = '0;
        repeat (5) tick;
        vectors++;
        if (tx_underflow_cnt !== 4'd5 || tx_read_allowed !== 1'b0) begin
            errors++;
            $display("FAIL ufl_count: ufl=%0d txa=%0b want 5 0", tx_underflow_cnt, tx_read_allowed);
        end
        repeat (15) tick;
        vectors++;
        if (tx_underflow_cnt !== 4'd15) begin
            errors++;
            $display("FAIL ufl_saturate: got %0d want 15", tx_underflow_cnt);
        end
        ctr_clear = 1;
        tick;
        ctr_clear = 0;
        vectors++;
        if (tx_underflow_cnt !== 4'd0) begin
            errors++;
            $display("FAIL clear_wins: got %0d want 0", tx_underflow_cnt);
        end
        tick;
        vectors++;
        if (tx_underflow_cnt !== 4'd1) begin
            errors++;
            $display("FAIL ufl_resume: got %0d want 1", tx_underflow_cnt);
        end
    endtask

    task automatic test_abort;
        tx_fifo_level = 13'd600;
        tick; tick;
        vectors++;
        if (tx_read_allowed !== 1'b1 || tx_underflow_cnt !== 4'd1) begin
            errors++;
            $display("FAIL pre_rst: txa=%0b ufl=%0d want 1 1", tx_read_allowed, tx_underflow_cnt);
        end
        #2 rst = 1;
        #1;
        vectors++;
        if ({state, enable, busy, rx_write_allowed, tx_read_allowed, tx_underflow_cnt} !== '0) begin
            errors++;
            $display("FAIL async_rst: st=%0d en=%0b busy=%0b rxa=%0b txa=%0b ufl=%0d want all 0",
                     state, enable, busy, rx_write_allowed, tx_read_allowed, tx_underflow_cnt);
        end
        tick;
        rst = 0;
        rx_en_req = 1; start = 1;
        tick;
        start = 0; rx_en_req = 0;
        repeat (5) tick;
        stop = 1;
        tick;
        stop = 0;
        vectors++;
        if (state !== 2'd0 || enable !== 1'b0) begin
            errors++;
            $display("FAIL arm_stop: st=%0d en=%0b want 0 0", state, enable);
        end
        rx_en_req = 1; start = 1; stop = 1;
        tick;
        start = 0; stop = 0; rx_en_req = 0;
        vectors++;
        if (state !== 2'd0 || enable !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_stop: st=%0d en=%0b busy=%0b want 0 0 0", state, enable, busy);
        end
        start = 1;
        tick;
        start = 0;
        vectors++;
        if (state !== 2'd0 || enable !== 1'b0) begin
            errors++;
            $display("FAIL start_noreq: st=%0d en=%0b want 0 0", state, enable);
        end
    endtask

    initial begin
        test_reset;
        test_rx_start;
        test_rx_throttle;
        test_drain;
        test_tx_prime;
        test_underflow;
        test_abort;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
